// File: rtl/vga_pkg.sv
// Shared VGA / framebuffer definitions for the video-RAM arbiter.
// Holds the display geometry, the 160x120 framebuffer geometry, the RGB word
// width, the arbiter state encoding and the beam-to-framebuffer address map.
package vga_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned COORD_W   = 10;

    localparam int unsigned FB_W      = 160;
    localparam int unsigned FB_H      = 120;
    localparam int unsigned FB_SHIFT  = 2;
    localparam int unsigned FB_ADDR_W = $clog2(FB_W * FB_H);

    localparam int unsigned RGB_W     = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

    // Beam position -> framebuffer word address; *160 done as *128 + *32.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        logic [FB_ADDR_W-1:0] xq;
        logic [FB_ADDR_W-1:0] yq;
        xq = FB_ADDR_W'(x >> FB_SHIFT);
        yq = FB_ADDR_W'(y >> FB_SHIFT);
        return (yq << 7) + (yq << 5) + xq;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-buffer FIFO carrying {addr,data} entries.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (drops all entries)
//   i_push/i_wdata: enqueue an entry (caller guarantees not full)
//   i_pop         : dequeue the head (caller guarantees not empty)
//   o_rdata_c     : head entry, combinational from storage
//   o_count       : registered number of stored entries
module vram_wr_fifo #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata_c,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video-RAM arbiter: display reads have absolute priority on every
// visible pixel strobe; game-logic writes are buffered and drained into free
// cycles. Pixels come back after a fixed 3-cycle pipeline.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   p_tick, display_on, x, y   : beam timing from vga_sync
//   wr_valid/wr_ready/wr_addr/wr_data : game-logic write port
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : single-port RAM interface
//   pix_rgb, pix_valid         : pixel to the DAC, one pulse per strobe
//   wr_overflow                : sticky, write attempted while buffer full
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned DATA_W     = RGB_W,
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p_tick,
    input  logic                 display_on,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata,
    output logic [DATA_W-1:0]    pix_rgb,
    output logic                 pix_valid,
    output logic                 wr_overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;

    logic                    w_disp_req;
    logic [FB_ADDR_W-1:0]    w_disp_addr;

    logic                    w_push;
    logic                    w_bypass;
    logic                    w_fifo_push;
    logic                    w_fifo_pop;
    logic                    w_wr_avail;
    logic [CNT_W-1:0]        w_count;
    logic                    w_full;
    logic                    w_empty;
    logic [ENT_W-1:0]        w_fifo_head;
    logic [ENT_W-1:0]        w_head;
    logic [ADDR_W-1:0]       w_head_addr;
    logic [DATA_W-1:0]       w_head_data;

    logic                    w_ram_en_nxt;
    logic                    w_ram_we_nxt;
    logic [ADDR_W-1:0]       w_ram_addr_nxt;
    logic [DATA_W-1:0]       w_ram_wdata_nxt;

    logic                    r_ram_en;
    logic                    r_ram_we;
    logic [ADDR_W-1:0]       r_ram_addr;
    logic [DATA_W-1:0]       r_ram_wdata;

    logic                    r_p1_valid;
    logic                    r_p2_valid;
    logic                    r_p2_rd;
    logic [DATA_W-1:0]       r_pix_rgb;
    logic                    r_pix_valid;
    logic                    r_wr_overflow;

    // Display request and its framebuffer address.
    assign w_disp_req  = p_tick & display_on
                       & (x < COORD_W'(H_DISPLAY))
                       & (y < COORD_W'(V_DISPLAY));
    assign w_disp_addr = fb_addr(x, y);

    // Write buffer status; ready depends on the registered count only.
    assign w_full   = (w_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (w_count == '0);
    assign wr_ready = ~w_full;
    assign w_push   = wr_valid & wr_ready;

    // An incoming write into an empty buffer in a free cycle goes straight to
    // the RAM port, giving the one-cycle minimum write latency.
    assign w_bypass    = w_push & w_empty & ~w_disp_req;
    assign w_wr_avail  = ~w_empty | w_push;
    assign w_fifo_push = w_push & ~w_bypass;
    assign w_fifo_pop  = (w_state_nxt == WR) & ~w_empty;
    assign w_head      = w_empty ? {wr_addr, wr_data} : w_fifo_head;
    assign w_head_addr = w_head[DATA_W +: ADDR_W];
    assign w_head_data = w_head[DATA_W-1:0];

    vram_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_fifo_push),
        .i_pop     (w_fifo_pop),
        .i_wdata   ({wr_addr, wr_data}),
        .o_rdata_c (w_fifo_head),
        .o_count   (w_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: display first, then any pending write.
    always_comb begin
        w_state_nxt = IDLE;
        if (w_disp_req) begin
            w_state_nxt = RD;
        end else if (w_wr_avail) begin
            w_state_nxt = WR;
        end
    end

    // RAM port values for the upcoming state; address/data hold when idle.
    always_comb begin
        w_ram_en_nxt    = 1'b0;
        w_ram_we_nxt    = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        unique case (w_state_nxt)
            RD: begin
                w_ram_en_nxt   = 1'b1;
                w_ram_addr_nxt = ADDR_W'(w_disp_addr);
            end
            WR: begin
                w_ram_en_nxt    = 1'b1;
                w_ram_we_nxt    = 1'b1;
                w_ram_addr_nxt  = w_head_addr;
                w_ram_wdata_nxt = w_head_data;
            end
            default: begin
            end
        endcase
    end

    // RAM port registers, aligned with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_en    <= w_ram_en_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
        end
    end

    // Pixel pipeline: strobe -> access cycle -> data cycle -> output.
    // Being in RD during the access cycle marks the strobe as a real read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_valid  <= 1'b0;
            r_p2_valid  <= 1'b0;
            r_p2_rd     <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_rgb   <= '0;
        end else begin
            r_p1_valid  <= p_tick;
            r_p2_valid  <= r_p1_valid;
            r_p2_rd     <= (r_state == RD);
            r_pix_valid <= r_p2_valid;
            if (r_p2_valid) begin
                r_pix_rgb <= r_p2_rd ? ram_rdata : '0;
            end
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_overflow <= 1'b0;
        end else if (wr_valid & ~wr_ready) begin
            r_wr_overflow <= 1'b1;
        end
    end

    assign ram_en      = r_ram_en;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign pix_rgb     = r_pix_rgb;
    assign pix_valid   = r_pix_valid;
    assign wr_overflow = r_wr_overflow;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, queue-based reference model of the
// arbitration rules, directed corner cases followed by randomized traffic.
module tb_vram_arbiter;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MEM_N  = 32768;

    logic              clk = 1'b0;
    logic              reset;
    logic              p_tick;
    logic              display_on;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] pix_rgb;
    logic              pix_valid;
    logic              wr_overflow;

    always #5 clk = ~clk;

    vram_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (p_tick),
        .display_on  (display_on),
        .x           (x),
        .y           (y),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .pix_rgb     (pix_rgb),
        .pix_valid   (pix_valid),
        .wr_overflow (wr_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_pat(input int a);
        return DATA_W'((a * 37) ^ 32'h5A5);
    endfunction

    // Behavioural single-port RAM with one-cycle read latency.
    logic [DATA_W-1:0] ram [MEM_N];
    bit                ram_wr [MEM_N];
    int                wlog[$];
    int                bad_hits = 0;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram[ram_addr]    <= ram_wdata;
                ram_wr[ram_addr] <= 1'b1;
                wlog.push_back(int'(ram_addr));
                if (ram_addr == 15'd19000 || ram_addr == 15'd19001) bad_hits++;
            end else begin
                ram_rdata <= ram_wr[ram_addr] ? ram[ram_addr] : init_pat(int'(ram_addr));
            end
        end
    end

    // Reference model: a queue of pending writes, a shadow of memory contents
    // and a list of pixels due at strobe cycle + 3.
    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
    typedef struct { int due; logic [DATA_W-1:0] val; } pix_t;

    wr_t               wq[$];
    pix_t              pq[$];
    logic [DATA_W-1:0] shadow [MEM_N];
    bit                shadow_wr [MEM_N];

    int                cyc = 0;
    bit                armed = 0;
    logic              e_en, e_we, e_pv, e_ovf;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_pix;
    bit                m_push, m_req;
    int                m_a;
    wr_t               m_w;
    pix_t              m_p;

    always @(negedge clk) begin
        cyc++;
        if (armed) begin
            check("ram_en", ram_en, e_en);
            check("ram_we", ram_we, e_we);
            check("ram_addr", ram_addr, e_addr);
            check("ram_wdata", ram_wdata, e_wdata);
            check("pix_valid", pix_valid, e_pv);
            check("pix_rgb", pix_rgb, e_pix);
            check("wr_overflow", wr_overflow, e_ovf);
            check("wr_ready", wr_ready, (wq.size() < int'(DEPTH)));
        end
        if (reset) begin
            wq.delete();
            pq.delete();
            e_en = 0; e_we = 0; e_pv = 0; e_ovf = 0;
            e_addr = '0; e_wdata = '0; e_pix = '0;
            armed = 1;
        end else if (armed) begin
            m_push = wr_valid && (wq.size() < int'(DEPTH));
            if (wr_valid && !m_push) e_ovf = 1;
            if (m_push) begin
                m_w.a = wr_addr; m_w.d = wr_data;
                wq.push_back(m_w);
            end
            m_req = p_tick && display_on && (x < 640) && (y < 480);
            if (m_req) begin
                m_a = (int'(y) / 4) * 160 + int'(x) / 4;
                e_en = 1; e_we = 0; e_addr = ADDR_W'(m_a);
                m_p.due = cyc + 3;
                m_p.val = shadow_wr[m_a] ? shadow[m_a] : init_pat(m_a);
                pq.push_back(m_p);
            end else begin
                if (p_tick) begin
                    m_p.due = cyc + 3; m_p.val = '0;
                    pq.push_back(m_p);
                end
                if (wq.size() > 0) begin
                    m_w = wq.pop_front();
                    e_en = 1; e_we = 1; e_addr = m_w.a; e_wdata = m_w.d;
                    shadow[m_w.a] = m_w.d;
                    shadow_wr[m_w.a] = 1;
                end else begin
                    e_en = 0; e_we = 0;
                end
            end
            if (pq.size() > 0 && pq[0].due == cyc + 1) begin
                e_pv = 1; e_pix = pq[0].val;
                pq.delete(0);
            end else begin
                e_pv = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int en_seen;
    int pv_seen;
    int mark;
    int gap;

    initial begin
        reset = 1; p_tick = 0; display_on = 0; x = '0; y = '0;
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();
        reset = 0;
        @(negedge clk);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_rgb", pix_rgb, 0);
        check("rst_overflow", wr_overflow, 0);
        check("rst_wr_ready", wr_ready, 1);

        en_seen = 0;
        repeat (100) begin
            tick();
            @(negedge clk);
            if (ram_en) en_seen++;
        end
        check("idle_no_ram_en", en_seen, 0);

        // Write 0xABC to 323 through the write port: lands one cycle after push.
        tick(); wr_valid = 1; wr_addr = 15'd323; wr_data = 12'hABC;
        tick(); wr_valid = 0;
        @(negedge clk);
        check("wr_min_lat_we", ram_we, 1);
        check("wr_min_lat_addr", ram_addr, 323);
        check("wr_min_lat_data", ram_wdata, 12'hABC);
        repeat (2) tick();

        // Strobe at (13,9): read of 323 at T+1, pixel at T+3.
        tick(); p_tick = 1; display_on = 1; x = 10'd13; y = 10'd9;
        tick(); p_tick = 0;
        @(negedge clk);
        check("rd_13_9_en", ram_en, 1);
        check("rd_13_9_we", ram_we, 0);
        check("rd_13_9_addr", ram_addr, 323);
        tick(); @(negedge clk);
        check("rd_13_9_no_early_pix", pix_valid, 0);
        tick(); @(negedge clk);
        check("pix_abc_valid", pix_valid, 1);
        check("pix_abc_rgb", pix_rgb, 12'hABC);
        tick(); @(negedge clk);
        check("pix_valid_pulse", pix_valid, 0);

        // Last visible pixel.
        tick(); p_tick = 1; display_on = 1; x = 10'd639; y = 10'd479;
        tick(); p_tick = 0;
        @(negedge clk);
        check("rd_corner_addr", ram_addr, 19199);
        repeat (3) tick();

        // Blank strobe: no RAM access, zero pixel on the read schedule.
        tick(); p_tick = 1; display_on = 0; x = 10'd5; y = 10'd5;
        tick(); p_tick = 0;
        @(negedge clk);
        check("blank_no_ram_en", ram_en, 0);
        tick(); tick(); @(negedge clk);
        check("blank_pix_valid", pix_valid, 1);
        check("blank_pix_rgb", pix_rgb, 0);
        repeat (2) tick();

        // Four writes interleaved with strobes every 2 cycles.
        mark = wlog.size();
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_valid = 1; wr_addr = ADDR_W'(10 + i); wr_data = DATA_W'(1 + i);
            p_tick = (i % 2 == 0); display_on = 1; x = 10'(8 * i); y = 10'd16;
        end
        tick(); wr_valid = 0; p_tick = 0;
        repeat (8) tick();
        check("order_cnt", wlog.size() - mark, 4);
        if (wlog.size() >= mark + 4)
            for (int i = 0; i < 4; i++) check("order_addr", wlog[mark + i], 10 + i);

        // Back-to-back strobes starve the write port so the buffer can fill.
        mark = wlog.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            p_tick = 1; display_on = 1; x = 10'(4 * i); y = 10'd0;
            wr_valid = 1; wr_addr = (i == 4) ? 15'd19000 : ADDR_W'(100 + i); wr_data = DATA_W'(i + 1);
            if (i == 4) begin
                @(negedge clk);
                check("full_wr_ready", wr_ready, 0);
            end
        end
        tick(); p_tick = 0; wr_valid = 0;
        @(negedge clk);
        check("ovf_set", wr_overflow, 1);
        check("full_ready_low_on_pop", wr_ready, 0);
        repeat (10) tick();
        check("fill_cnt", wlog.size() - mark, 4);
        if (wlog.size() >= mark + 4)
            for (int i = 0; i < 4; i++) check("fill_order", wlog[mark + i], 100 + i);
        check("dropped_write_not_issued", bad_hits, 0);
        check("ovf_sticky", wr_overflow, 1);

        // Strobe and push together into an empty buffer: RD then WR.
        tick(); p_tick = 1; display_on = 1; x = 10'd20; y = 10'd20;
        wr_valid = 1; wr_addr = 15'd777; wr_data = 12'h5A5;
        tick(); p_tick = 0; wr_valid = 0;
        @(negedge clk);
        check("same_cyc_rd_en", ram_en, 1);
        check("same_cyc_rd_we", ram_we, 0);
        tick(); @(negedge clk);
        check("same_cyc_wr_we", ram_we, 1);
        check("same_cyc_wr_addr", ram_addr, 777);
        check("same_cyc_wr_data", ram_wdata, 12'h5A5);
        repeat (3) tick();

        // Reset one cycle after a strobe that also buffered a write.
        tick(); p_tick = 1; display_on = 1; x = 10'd40; y = 10'd40;
        wr_valid = 1; wr_addr = 15'd19001; wr_data = 12'h001;
        tick(); p_tick = 0; wr_valid = 0; reset = 1;
        tick(); reset = 0;
        pv_seen = 0;
        repeat (5) begin
            @(negedge clk);
            pv_seen += int'(pix_valid);
            tick();
        end
        @(negedge clk);
        check("rst_mid_no_pix", pv_seen, 0);
        check("rst_mid_wr_ready", wr_ready, 1);
        check("rst_mid_overflow", wr_overflow, 0);
        check("rst_mid_write_dropped", bad_hits, 0);

        // Randomized traffic with legal strobe spacing and rare resets.
        gap = 2;
        for (int c = 0; c < 4000; c++) begin
            tick();
            reset = ($urandom_range(0, 599) == 0);
            gap++;
            if (gap >= 2 && $urandom_range(0, 2) != 0) begin
                p_tick = 1; gap = 0;
            end else begin
                p_tick = 0;
            end
            display_on = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) != 0) begin
                x = 10'($urandom_range(0, 63));
                y = 10'($urandom_range(0, 31));
            end else begin
                x = 10'($urandom_range(0, 1023));
                y = 10'($urandom_range(0, 1023));
            end
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_addr  = ADDR_W'($urandom_range(0, 7) * 160 + $urandom_range(0, 15));
            wr_data  = DATA_W'($urandom);
        end
        tick(); reset = 0; p_tick = 0; wr_valid = 0;
        repeat (20) tick();
        check("final_no_bad_writes", bad_hits, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
